leddc_stream_tx: RTL and testbench



---
 rtl/leddc_stream_tx_if.sv | 19 +
 rtl/leddc_stream_tx.sv | 112 +++++++++++
 tb/tb_leddc_stream_tx.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/leddc_stream_tx_if.sv
// Word handshake between the frame-buffer reader and the DCK serializer.
// The reader is the master; the serializer accepts on s_valid & s_ready.
interface leddc_stream_tx_if;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;

  modport master (
    output s_data,
    output s_valid,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    output s_ready
  );
endinterface

// File: rtl/leddc_stream_tx.sv
// DCK-domain gray-scale serializer: 16-bit words out LSB first on DAI/DEN.
// Sends WORDS words per frame, back-to-back when the source keeps up.
module leddc_stream_tx #(
  parameter int WORDS = 256,
  parameter int UCW   = 8
) (
  input  logic                DCK,
  input  logic                rst,
  input  logic                start,
  leddc_stream_tx_if.slave    s,
  output logic                DAI,
  output logic                DEN,
  output logic                busy,
  output logic                frame_done,
  output logic [8:0]          word_cnt,
  output logic [UCW-1:0]      underrun_cnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [9:0]     LAST_W = 10'(WORDS);
  localparam logic [UCW-1:0] UC_MAX = {UCW{1'b1}};

  logic [1:0]  state;
  logic [3:0]  bit_cnt;
  logic [15:0] shift;
  logic        last_bit;
  logic        more;
  logic [9:0]  next_cnt;

  assign last_bit = (bit_cnt == 4'd15);
  assign next_cnt = {1'b0, word_cnt} + 10'd1;
  assign more     = (next_cnt < LAST_W);

  // ready in WAIT, or on the final bit when another word is still due
  always_comb begin
    s.s_ready = 1'b0;
    unique case (state)
      WAIT:    s.s_ready = ~rst;
      SHIFT:   s.s_ready = ~rst & last_bit & more;
      default: s.s_ready = 1'b0;
    endcase
  end

  // frame sequencing, shifting and counters
  always_ff @(posedge DCK) begin
    if (rst) begin
      state        <= IDLE;
      bit_cnt      <= 4'd0;
      shift        <= 16'd0;
      DAI          <= 1'b0;
      DEN          <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      word_cnt     <= 9'd0;
      underrun_cnt <= '0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= WAIT;
            busy     <= 1'b1;
            word_cnt <= 9'd0;
          end
        end
        WAIT: begin
          if (s.s_valid) begin
            state   <= SHIFT;
            shift   <= s.s_data;
            DAI     <= s.s_data[0];
            DEN     <= 1'b1;
            bit_cnt <= 4'd0;
          end
        end
        SHIFT: begin
          if (!last_bit) begin
            bit_cnt <= bit_cnt + 4'd1;
            DAI     <= shift[bit_cnt + 4'd1];
          end else begin
            word_cnt <= word_cnt + 9'd1;
            if (!more) begin
              state      <= DONE;
              DEN        <= 1'b0;
              DAI        <= 1'b0;
              frame_done <= 1'b1;
            end else if (s.s_valid) begin
              shift   <= s.s_data;
              DAI     <= s.s_data[0];
              bit_cnt <= 4'd0;
            end else begin
              state <= WAIT;
              DEN   <= 1'b0;
              DAI   <= 1'b0;
              if (underrun_cnt != UC_MAX)
                underrun_cnt <= underrun_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_leddc_stream_tx.sv
// Directed bench for leddc_stream_tx with a receiver model and scoreboard.
// Three instances: WORDS=4, WORDS=1, WORDS=256.
module tb_leddc_stream_tx;

  logic clk;
  logic rst;
  logic [2:0]  st;
  logic [2:0]  vld;
  logic [15:0] dat [3];
  logic [2:0]  rdy;
  logic [2:0]  dai;
  logic [2:0]  den;
  logic [2:0]  bsy;
  logic [2:0]  fd;
  logic [8:0]  wc [3];
  logic [7:0]  uc [3];

  int checks = 0;
  int errors = 0;

  leddc_stream_tx_if bus0 ();
  leddc_stream_tx_if bus1 ();
  leddc_stream_tx_if bus2 ();

  assign bus0.s_valid = vld[0];
  assign bus0.s_data  = dat[0];
  assign rdy[0]       = bus0.s_ready;
  assign bus1.s_valid = vld[1];
  assign bus1.s_data  = dat[1];
  assign rdy[1]       = bus1.s_ready;
  assign bus2.s_valid = vld[2];
  assign bus2.s_data  = dat[2];
  assign rdy[2]       = bus2.s_ready;

  leddc_stream_tx #(.WORDS(4), .UCW(8)) u0 (
    .DCK(clk), .rst(rst), .start(st[0]), .s(bus0),
    .DAI(dai[0]), .DEN(den[0]), .busy(bsy[0]),
    .frame_done(fd[0]), .word_cnt(wc[0]),
    .underrun_cnt(uc[0])
  );

  leddc_stream_tx #(.WORDS(1), .UCW(8)) u1 (
    .DCK(clk), .rst(rst), .start(st[1]), .s(bus1),
    .DAI(dai[1]), .DEN(den[1]), .busy(bsy[1]),
    .frame_done(fd[1]), .word_cnt(wc[1]),
    .underrun_cnt(uc[1])
  );

  leddc_stream_tx #(.WORDS(256), .UCW(8)) u2 (
    .DCK(clk), .rst(rst), .start(st[2]), .s(bus2),
    .DAI(dai[2]), .DEN(den[2]), .busy(bsy[2]),
    .frame_done(fd[2]), .word_cnt(wc[2]),
    .underrun_cnt(uc[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [15:0] sbq [$];
  logic [15:0] rx_sh [3];
  int rx_bits [3];
  int den_run [3];
  int last_run [3];
  int gap_run [3];
  int max_gap [3];
  int partial [3];
  int done_cnt [3];
  int rdy_shift [3];
  int rx_addr;
  logic [15:0] mem [256];
  logic [15:0] ref_w [256];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_stats(int k);
    den_run[k]   = 0;
    last_run[k]  = 0;
    gap_run[k]   = 0;
    max_gap[k]   = 0;
    partial[k]   = 0;
    done_cnt[k]  = 0;
    rdy_shift[k] = 0;
  endtask

  // receiver model: rebuild words from DAI while DEN is high
  always @(negedge clk) begin
    logic [15:0] e;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        rx_bits[k] = 0;
        den_run[k] = 0;
        gap_run[k] = 0;
      end else begin
        if (vld[k] && rdy[k]) sbq.push_back(dat[k]);
        if (fd[k]) done_cnt[k]++;
        if (rdy[k] && den[k]) rdy_shift[k]++;
        if (den[k]) begin
          if (gap_run[k] > max_gap[k]) max_gap[k] = gap_run[k];
          gap_run[k] = 0;
          den_run[k]++;
          rx_sh[k] = {dai[k], rx_sh[k][15:1]};
          rx_bits[k]++;
          if (rx_bits[k] == 16) begin
            rx_bits[k] = 0;
            chk("sb_has_word", 32'(sbq.size() > 0), 32'd1);
            if (sbq.size() > 0) begin
              e = sbq.pop_front();
              chk("rx_word", 32'(rx_sh[k]), 32'(e));
            end
            if (k == 2 && rx_addr < 256) begin
              mem[rx_addr] = rx_sh[k];
              rx_addr++;
            end
          end
        end else begin
          if (den_run[k] != 0) last_run[k] = den_run[k];
          den_run[k] = 0;
          if (rx_bits[k] != 0) partial[k]++;
          rx_bits[k] = 0;
          if (bsy[k]) gap_run[k]++;
        end
      end
    end
    if (rst) sbq.delete();
  end

  task automatic pulse_start(int k);
    @(posedge clk); #1 st[k] = 1'b1;
    @(posedge clk); #1 st[k] = 1'b0;
  endtask

  task automatic send_word(int k, logic [15:0] d);
    bit ok;
    ok = 1'b0;
    vld[k] = 1'b1;
    dat[k] = d;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (rdy[k]) begin
        ok = 1'b1;
        break;
      end
    end
    chk("accept", 32'(ok), 32'd1);
    @(posedge clk); #1 vld[k] = 1'b0;
  endtask

  task automatic wait_done(int k, int n);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (fd[k]) begin
        ok = 1'b1;
        break;
      end
    end
    chk("done_seen", 32'(ok), 32'd1);
  endtask

  task automatic wait_den_low(int k);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!den[k]) begin
        ok = 1'b1;
        break;
      end
    end
    chk("den_fall", 32'(ok), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    st  = '0;
    vld = '0;
    rx_addr = 0;
    for (int k = 0; k < 3; k++) begin
      dat[k] = 16'd0;
      rx_sh[k] = 16'd0;
      rx_bits[k] = 0;
      clear_stats(k);
    end

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_den", 32'(den[0]), 32'd0);
    chk("rst_dai", 32'(dai[0]), 32'd0);
    chk("rst_busy", 32'(bsy[0]), 32'd0);
    chk("rst_fd", 32'(fd[0]), 32'd0);
    chk("rst_wc", 32'(wc[0]), 32'd0);
    chk("rst_uc", 32'(uc[0]), 32'd0);
    chk("rst_rdy", 32'(rdy), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // single word, WORDS=1
    vld[1] = 1'b1;
    dat[1] = 16'hA5C3;
    pulse_start(1);
    @(negedge clk);
    chk("w1_wait_den", 32'(den[1]), 32'd0);
    chk("w1_wait_busy", 32'(bsy[1]), 32'd1);
    chk("w1_wait_rdy", 32'(rdy[1]), 32'd1);
    @(negedge clk);
    chk("w1_lat_den", 32'(den[1]), 32'd1);
    chk("w1_bit0", 32'(dai[1]), 32'd1);
    chk("w1_shift_rdy", 32'(rdy[1]), 32'd0);
    @(posedge clk); #1 vld[1] = 1'b0;
    wait_done(1, 40);
    chk("w1_wc", 32'(wc[1]), 32'd1);
    chk("w1_busy_in_done", 32'(bsy[1]), 32'd1);
    chk("w1_den_in_done", 32'(den[1]), 32'd0);
    @(negedge clk);
    chk("w1_busy_after", 32'(bsy[1]), 32'd0);
    chk("w1_fd_once", 32'(fd[1]), 32'd0);
    chk("w1_done_cnt", 32'(done_cnt[1]), 32'd1);
    chk("w1_den_run", 32'(last_run[1]), 32'd16);
    chk("w1_sb_empty", 32'(sbq.size()), 32'd0);

    // back-to-back, WORDS=4, start pulsed at bit 7 of word 2
    pulse_start(0);
    send_word(0, 16'h0001);
    send_word(0, 16'h8000);
    repeat (7) @(posedge clk);
    #1 st[0] = 1'b1;
    @(posedge clk); #1 st[0] = 1'b0;
    chk("b2b_busy_mid", 32'(bsy[0]), 32'd1);
    chk("b2b_wc_mid", 32'(wc[0]), 32'd1);
    send_word(0, 16'hFFFF);
    send_word(0, 16'h0000);
    wait_done(0, 40);
    chk("b2b_wc", 32'(wc[0]), 32'd4);
    chk("b2b_busy_in_done", 32'(bsy[0]), 32'd1);
    @(negedge clk);
    chk("b2b_busy_after", 32'(bsy[0]), 32'd0);
    chk("b2b_den_run", 32'(last_run[0]), 32'd64);
    chk("b2b_rdy_pulses", 32'(rdy_shift[0]), 32'd3);
    chk("b2b_done_cnt", 32'(done_cnt[0]), 32'd1);
    chk("b2b_uc", 32'(uc[0]), 32'd0);
    chk("b2b_partial", 32'(partial[0]), 32'd0);
    chk("b2b_sb_empty", 32'(sbq.size()), 32'd0);
    repeat (4) @(negedge clk);
    chk("b2b_stay_idle", 32'(bsy[0]), 32'd0);
    chk("b2b_wc_hold", 32'(wc[0]), 32'd4);

    // underrun between word 1 and word 2
    clear_stats(0);
    pulse_start(0);
    send_word(0, 16'h1234);
    wait_den_low(0);
    chk("ur_uc_now", 32'(uc[0]), 32'd1);
    chk("ur_wc_now", 32'(wc[0]), 32'd1);
    @(posedge clk); #1 st[0] = 1'b1;
    @(posedge clk); #1 st[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("ur_wc_gap", 32'(wc[0]), 32'd1);
    chk("ur_busy_gap", 32'(bsy[0]), 32'd1);
    send_word(0, 16'hBEEF);
    send_word(0, 16'h5A5A);
    send_word(0, 16'h0F0F);
    wait_done(0, 40);
    chk("ur_wc", 32'(wc[0]), 32'd4);
    @(negedge clk);
    chk("ur_uc", 32'(uc[0]), 32'd1);
    chk("ur_gap_ge5", 32'(max_gap[0] >= 5), 32'd1);
    chk("ur_partial", 32'(partial[0]), 32'd0);
    chk("ur_done_cnt", 32'(done_cnt[0]), 32'd1);
    chk("ur_last_run", 32'(last_run[0]), 32'd48);
    chk("ur_sb_empty", 32'(sbq.size()), 32'd0);

    // reset at bit_cnt=9 of the first word
    clear_stats(0);
    pulse_start(0);
    send_word(0, 16'hC0DE);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mr_den", 32'(den[0]), 32'd0);
    chk("mr_busy", 32'(bsy[0]), 32'd0);
    chk("mr_wc", 32'(wc[0]), 32'd0);
    chk("mr_uc", 32'(uc[0]), 32'd0);
    chk("mr_sb_flushed", 32'(sbq.size()), 32'd0);
    clear_stats(0);
    pulse_start(0);
    send_word(0, 16'h8421);
    send_word(0, 16'h7E81);
    send_word(0, 16'h0003);
    send_word(0, 16'hFFFE);
    wait_done(0, 40);
    chk("mr2_wc", 32'(wc[0]), 32'd4);
    @(negedge clk);
    chk("mr2_den_run", 32'(last_run[0]), 32'd64);
    chk("mr2_partial", 32'(partial[0]), 32'd0);
    chk("mr2_sb_empty", 32'(sbq.size()), 32'd0);

    // end-to-end, WORDS=256, random data into the line buffer model
    clear_stats(2);
    rx_addr = 0;
    for (int i = 0; i < 256; i++) ref_w[i] = 16'($urandom);
    pulse_start(2);
    for (int i = 0; i < 256; i++) send_word(2, ref_w[i]);
    wait_done(2, 40);
    chk("e2e_wc", 32'(wc[2]), 32'd256);
    @(negedge clk);
    chk("e2e_den_run", 32'(last_run[2]), 32'd4096);
    chk("e2e_uc", 32'(uc[2]), 32'd0);
    chk("e2e_addr", 32'(rx_addr), 32'd256);
    for (int i = 0; i < 256; i++)
      chk("e2e_mem", 32'(mem[i]), 32'(ref_w[i]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
